tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Single-clock run controller and tick-enable generator for the waveform-sample design. It replaces free-running behavioural clocks with three synthesizable divided enables (fast, medium and slow) derived from one `clk`. It also sequences a bounded run (idle → run → done) of programmable length. The `sub` instances consume these enables, or the phase outputs, instead of separate clocks.

## Interface
Parameters:
- `DIV_W`, 16: width of each divisor.
- `RUN_W`, 32: width of the run-length and cycle counters.
- `DEF_FAST`, 1: divisor used when `div_fast` is 0.
- `DEF_MED`, 100: divisor used when `div_med` is 0.
- `DEF_SLOW`, 1000: divisor used when `div_slow` is 0.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, sampled in IDLE only.
- `stop` in 1: abort request.
- `run_len` in RUN_W: run length in `clk` cycles; 0 means free-run until `stop`.
- `div_fast`, `div_med`, `div_slow` in DIV_W each: divisors, latched on an accepted `start`.
- `fast_en`, `med_en`, `slow_en` out 1 each: one-cycle tick pulses.
- `fast_ph`, `med_ph`, `slow_ph` out 1 each: phase outputs that toggle on each tick.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse on run completion.
- `cycle_cnt` out RUN_W: number of RUN cycles elapsed.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN when `start & ~stop`. On that transition, latch `run_len` and all three divisors. A zero divisor is replaced by its DEF_* parameter.
- RUN → DONE when `stop`, or when `run_len != 0` and `cycle_cnt == run_len-1`.
- DONE → IDLE unconditionally after one cycle.
- `start` in RUN or DONE is ignored. `stop` in IDLE or DONE is ignored.
- Each divider holds a counter `c` and a latched divisor `d`:
  - In RUN, `c` counts 0..d-1 and wraps to 0.
  - `*_en = (state==RUN) & (c == d-1)`.
  - `*_ph` toggles on each `*_en`.
  - Outside RUN, `c` holds at 0.
- `cycle_cnt` behaviour:
  - Cleared to 0 on an accepted `start`.
  - Increments once per RUN cycle.
  - Saturates at all-ones when in free-run.
  - Holds its value through DONE and IDLE until the next accepted `start`.
- The phase outputs clear to 0 on an accepted `start` and otherwise hold outside RUN.
- Reset values: `busy`, `done`, every `*_en`, every `*_ph` and `cycle_cnt` are 0; state is IDLE; the divider counters are 0.
- Reset mid-run aborts immediately with no `done` pulse.

## Timing
- `start` is accepted at edge T. `busy=1` from T+1, which is the first RUN cycle; `cycle_cnt` reads 0 in that cycle.
- With divisor d, the first tick is at RUN cycle d-1 (edge T+d); subsequent ticks follow every d cycles. With d=1 the tick is high in every RUN cycle.
- Every output is registered; there is no combinational path from input to output.
- A run of length N occupies exactly N RUN cycles. DONE is in cycle T+N+1 with `done=1`, `busy=0`, all `*_en` low and `cycle_cnt=N`.
- `stop` sampled in RUN cycle S: cycle S is still a RUN cycle, and ticks may fire in it. DONE follows in S+1.
- `start` and `stop` asserted together in IDLE: `stop` wins and the FSM stays in IDLE.
- `stop` asserted in the same cycle the run length expires: a single DONE, with no difference in behaviour.
- Earliest restart: `start` is accepted in the IDLE cycle immediately after DONE.

## Configuration
- Macro `TICK_SCHEDULER_PHASE_EN`.
- Defined: the `*_ph` toggle outputs are implemented as specified.
- Undefined: the `*_ph` outputs are tied to 0 and the phase flops are removed. Enables, FSM and counters are unchanged.

## Structure
- Package `tick_scheduler_pkg` holds:
  - the `state_t` enum (IDLE, RUN, DONE);
  - the default divisor constants (DEF_FAST, DEF_MED, DEF_SLOW) used as the parameter defaults.
- Sub-module `tick_div` contains:
  - divisor latch, counter, enable and phase logic;
  - inputs: `clk`, `rst`, `load`, `run`, `div_in`;
  - outputs: `en`, `ph`.
  - It is instantiated three times. The top-level module holds the FSM and `cycle_cnt`.

## Test plan
- Reset, then `start` with `run_len=20` and divisors 1/4/10:
  - `busy` high for exactly 20 cycles;
  - `fast_en` fires 20 times, `med_en` 5 times and `slow_en` 2 times;
  - one `done` pulse with `cycle_cnt=20`.
- Free-run (`run_len=0`) with all divisors 0:
  - the defaults 1/100/1000 apply;
  - `med_en` first fires at RUN cycle 99 and `slow_en` at RUN cycle 999;
  - `stop` at RUN cycle 2500 gives DONE at cycle 2501 and `cycle_cnt=2501`.
- `start` and `stop` together in IDLE: the FSM stays in IDLE, `busy` stays 0 and no `done` pulse occurs.
- `start` pulsed during RUN (`run_len=8`): ignored, and the run still ends after 8 cycles.
- `rst` asserted at RUN cycle 5: the next cycle shows every output at 0 and no `done` pulse; a new `start` then runs normally.
- With `TICK_SCHEDULER_PHASE_EN` defined and divisor 2, `fast_ph` reads 0,1,1,0,0,1,… over successive RUN cycles. With the macro undefined, `fast_ph` is constantly 0.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
// ============================================================================
// Module      : tick_scheduler_pkg
// Description : Shared types and default divisor constants for the
//               tick_scheduler run controller.
//               Optional feature macro: TICK_SCHEDULER_PHASE_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_scheduler_pkg;

    // Run controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Divisors substituted when a zero divisor is latched
    localparam int DEF_FAST = 1;
    localparam int DEF_MED  = 100;
    localparam int DEF_SLOW = 1000;

endpackage

`default_nettype wire

// File: rtl/tick_scheduler_div.sv
// ============================================================================
// Module      : tick_div
// Description : One divided tick-enable channel. Latches its divisor on load,
//               counts 0..d-1 while running and registers a one-cycle tick
//               on the last count. Optional phase output toggles per tick.
//               Optional feature macro: TICK_SCHEDULER_PHASE_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_div #(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,     // next cycle is the first RUN cycle
    input  logic             run,      // current and next cycle are RUN
    input  logic [DIV_W-1:0] div_in,
    output logic             en,
    output logic             ph
);

    import tick_scheduler_pkg::*;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] cnt_nxt;
    logic             tick_nxt;

    // Effective divisor, next counter value and the registered-tick decision.
    // The counter value always reflects the RUN cycle it is visible in, so the
    // tick flop is loaded from the value the counter takes on this edge.
    always_comb begin
        div_eff  = (div_in == '0) ? DIV_W'(DEF_DIV) : div_in;
        cnt_nxt  = (cnt_q == div_q - ONE) ? '0 : cnt_q + ONE;
        tick_nxt = 1'b0;
        if (load) begin
            tick_nxt = (div_eff == ONE);
        end else if (run) begin
            tick_nxt = (cnt_nxt == div_q - ONE);
        end
    end

    // Divisor latch, counter and tick register
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DIV_W'(DEF_DIV);
            cnt_q <= '0;
            en    <= 1'b0;
        end else if (load) begin
            div_q <= div_eff;
            cnt_q <= '0;
            en    <= tick_nxt;
        end else if (run) begin
            cnt_q <= cnt_nxt;
            en    <= tick_nxt;
        end else begin
            cnt_q <= '0;
            en    <= 1'b0;
        end
    end

`ifdef TICK_SCHEDULER_PHASE_EN
    // Phase flop: cleared at run start (then toggled if the first cycle
    // already ticks), toggled with every tick, held outside RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            ph <= 1'b0;
        end else if (load) begin
            ph <= tick_nxt;
        end else if (run && tick_nxt) begin
            ph <= ~ph;
        end
    end
`else
    assign ph = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/tick_scheduler.sv
// ============================================================================
// Module      : tick_scheduler
// Description : Single-clock run controller (IDLE -> RUN -> DONE) with a
//               programmable run length and three divided tick enables.
//               Optional feature macro: TICK_SCHEDULER_PHASE_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_scheduler #(
    parameter int DIV_W    = 16,
    parameter int RUN_W    = 32,
    parameter int DEF_FAST = tick_scheduler_pkg::DEF_FAST,
    parameter int DEF_MED  = tick_scheduler_pkg::DEF_MED,
    parameter int DEF_SLOW = tick_scheduler_pkg::DEF_SLOW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [RUN_W-1:0] run_len,
    input  logic [DIV_W-1:0] div_fast,
    input  logic [DIV_W-1:0] div_med,
    input  logic [DIV_W-1:0] div_slow,
    output logic             fast_en,
    output logic             med_en,
    output logic             slow_en,
    output logic             fast_ph,
    output logic             med_ph,
    output logic             slow_ph,
    output logic             busy,
    output logic             done,
    output logic [RUN_W-1:0] cycle_cnt
);

    import tick_scheduler_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic [RUN_W-1:0] len_q;
    logic             accept;
    logic             last_cycle;
    logic             run_cont;

    // Next-state logic; accept marks the edge that latches run parameters
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        last_cycle = (len_q != '0) && (cycle_cnt == len_q - RUN_W'(1));
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end
            end
            RUN: begin
                if (stop || last_cycle) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        run_cont = (state == RUN) && (state_nxt == RUN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered status outputs, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == DONE);
        end
    end

    // Run length latch and saturating RUN-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            cycle_cnt <= '0;
        end else if (accept) begin
            len_q     <= run_len;
            cycle_cnt <= '0;
        end else if ((state == RUN) && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + RUN_W'(1);
        end
    end

    tick_div #(.DIV_W(DIV_W), .DEF_DIV(DEF_FAST)) u_div_fast (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .run    (run_cont),
        .div_in (div_fast),
        .en     (fast_en),
        .ph     (fast_ph)
    );

    tick_div #(.DIV_W(DIV_W), .DEF_DIV(DEF_MED)) u_div_med (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .run    (run_cont),
        .div_in (div_med),
        .en     (med_en),
        .ph     (med_ph)
    );

    tick_div #(.DIV_W(DIV_W), .DEF_DIV(DEF_SLOW)) u_div_slow (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .run    (run_cont),
        .div_in (div_slow),
        .en     (slow_en),
        .ph     (slow_ph)
    );

endmodule

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// ============================================================================
// Module      : tb_tick_scheduler
// Description : Directed self-checking bench for tick_scheduler.
//               Phase expectations follow TICK_SCHEDULER_PHASE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_scheduler;

    localparam int DIV_W = 16;
    localparam int RUN_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic [RUN_W-1:0] run_len;
    logic [DIV_W-1:0] div_fast;
    logic [DIV_W-1:0] div_med;
    logic [DIV_W-1:0] div_slow;
    logic             fast_en;
    logic             med_en;
    logic             slow_en;
    logic             fast_ph;
    logic             med_ph;
    logic             slow_ph;
    logic             busy;
    logic             done;
    logic [RUN_W-1:0] cycle_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tick_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .run_len   (run_len),
        .div_fast  (div_fast),
        .div_med   (div_med),
        .div_slow  (div_slow),
        .fast_en   (fast_en),
        .med_en    (med_en),
        .slow_en   (slow_en),
        .fast_ph   (fast_ph),
        .med_ph    (med_ph),
        .slow_ph   (slow_ph),
        .busy      (busy),
        .done      (done),
        .cycle_cnt (cycle_cnt)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        run_len = '0; div_fast = '0; div_med = '0; div_slow = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, fast_en, med_en, slow_en, fast_ph, med_ph, slow_ph} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {busy, done, fast_en, med_en, slow_en, fast_ph, med_ph, slow_ph});
        end
        checks++;
        if (cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bounded_run();
        int n_busy = 0, n_fast = 0, n_med = 0, n_slow = 0, n_done = 0;
        int done_at = -1, en_out = 0;
        logic [RUN_W-1:0] done_cnt = '1;
        logic first_busy;
        logic [RUN_W-1:0] first_cnt;
        run_len = 32'd20; div_fast = 16'd1; div_med = 16'd4; div_slow = 16'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_busy = busy;
        first_cnt  = cycle_cnt;
        for (int i = 0; i < 30; i++) begin
            if (busy) n_busy++;
            if (fast_en) n_fast++;
            if (med_en) n_med++;
            if (slow_en) n_slow++;
            if (!busy && (fast_en || med_en || slow_en)) en_out++;
            if (done) begin n_done++; done_at = i; done_cnt = cycle_cnt; end
            @(negedge clk);
        end
        checks++;
        if (first_busy !== 1'b1 || first_cnt !== 32'd0) begin
            errors++;
            $display("FAIL bounded_first_cycle: busy=%b cnt=%0d expected busy=1 cnt=0", first_busy, first_cnt);
        end
        checks++;
        if (n_busy !== 20) begin errors++; $display("FAIL bounded_busy_cycles: got %0d expected 20", n_busy); end
        checks++;
        if (n_fast !== 20) begin errors++; $display("FAIL bounded_fast_ticks: got %0d expected 20", n_fast); end
        checks++;
        if (n_med !== 5) begin errors++; $display("FAIL bounded_med_ticks: got %0d expected 5", n_med); end
        checks++;
        if (n_slow !== 2) begin errors++; $display("FAIL bounded_slow_ticks: got %0d expected 2", n_slow); end
        checks++;
        if (n_done !== 1 || done_at !== 20) begin
            errors++;
            $display("FAIL bounded_done: pulses=%0d at=%0d expected 1 at 20", n_done, done_at);
        end
        checks++;
        if (done_cnt !== 32'd20) begin errors++; $display("FAIL bounded_done_cnt: got %0d expected 20", done_cnt); end
        checks++;
        if (en_out !== 0) begin errors++; $display("FAIL bounded_en_outside_run: got %0d expected 0", en_out); end
        checks++;
        if (cycle_cnt !== 32'd20) begin errors++; $display("FAIL bounded_cnt_hold: got %0d expected 20", cycle_cnt); end
    endtask

    task automatic test_free_run();
        int n_busy = 0, n_fast = 0, n_med = 0, n_slow = 0, n_done = 0;
        int first_med = -1, first_slow = -1, done_at = -1;
        logic [RUN_W-1:0] done_cnt = '1;
        logic first_fast;
        run_len = '0; div_fast = '0; div_med = '0; div_slow = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_fast = fast_en;
        for (int i = 0; i < 2510; i++) begin
            if (busy) n_busy++;
            if (fast_en) n_fast++;
            if (med_en) begin n_med++; if (first_med < 0) first_med = i; end
            if (slow_en) begin n_slow++; if (first_slow < 0) first_slow = i; end
            if (done) begin n_done++; done_at = i; done_cnt = cycle_cnt; end
            stop = (i == 2500);
            @(negedge clk);
        end
        stop = 1'b0;
        checks++;
        if (first_fast !== 1'b1) begin errors++; $display("FAIL free_fast_first: got %b expected 1", first_fast); end
        checks++;
        if (first_med !== 99) begin errors++; $display("FAIL free_med_first: got %0d expected 99", first_med); end
        checks++;
        if (first_slow !== 999) begin errors++; $display("FAIL free_slow_first: got %0d expected 999", first_slow); end
        checks++;
        if (n_fast !== 2501 || n_med !== 25 || n_slow !== 2) begin
            errors++;
            $display("FAIL free_tick_counts: got %0d/%0d/%0d expected 2501/25/2", n_fast, n_med, n_slow);
        end
        checks++;
        if (n_busy !== 2501) begin errors++; $display("FAIL free_busy_cycles: got %0d expected 2501", n_busy); end
        checks++;
        if (n_done !== 1 || done_at !== 2501) begin
            errors++;
            $display("FAIL free_done: pulses=%0d at=%0d expected 1 at 2501", n_done, done_at);
        end
        checks++;
        if (done_cnt !== 32'd2501) begin errors++; $display("FAIL free_done_cnt: got %0d expected 2501", done_cnt); end
    endtask

    task automatic test_start_stop_idle();
        int n_busy = 0, n_done = 0;
        start = 1'b1; stop = 1'b1; run_len = 32'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) n_done++;
        end
        start = 1'b0; stop = 1'b0;
        checks++;
        if (n_busy !== 0 || n_done !== 0) begin
            errors++;
            $display("FAIL start_stop_idle: busy=%0d done=%0d expected 0/0", n_busy, n_done);
        end
        checks++;
        if (cycle_cnt !== 32'd2501) begin
            errors++;
            $display("FAIL start_stop_idle_cnt: got %0d expected 2501", cycle_cnt);
        end
    endtask

    task automatic test_start_during_run();
        int n_busy = 0, n_done = 0, done_at = -1;
        logic [RUN_W-1:0] done_cnt = '1;
        run_len = 32'd8; div_fast = 16'd1; div_med = 16'd2; div_slow = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (busy) n_busy++;
            if (done) begin n_done++; done_at = i; done_cnt = cycle_cnt; end
            start = (i == 3) || (i == 8);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (n_busy !== 8) begin errors++; $display("FAIL restart_ignored_busy: got %0d expected 8", n_busy); end
        checks++;
        if (n_done !== 1 || done_at !== 8 || done_cnt !== 32'd8) begin
            errors++;
            $display("FAIL restart_ignored_done: pulses=%0d at=%0d cnt=%0d expected 1 at 8 cnt 8",
                     n_done, done_at, done_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int n_busy = 0, n_done = 0, done_at = -1;
        logic [RUN_W-1:0] done_cnt = '1;
        run_len = 32'd20; div_fast = 16'd1; div_med = 16'd1; div_slow = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, fast_en, med_en, slow_en, fast_ph, med_ph, slow_ph} !== 8'b0 || cycle_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: got %b cnt=%0d expected 00000000 cnt=0",
                     {busy, done, fast_en, med_en, slow_en, fast_ph, med_ph, slow_ph}, cycle_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (done) n_done++;
        end
        checks++;
        if (n_busy !== 0 || n_done !== 0) begin
            errors++;
            $display("FAIL midrun_reset_quiet: busy=%0d done=%0d expected 0/0", n_busy, n_done);
        end
        n_busy = 0; n_done = 0;
        run_len = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy) n_busy++;
            if (done) begin n_done++; done_at = i; done_cnt = cycle_cnt; end
            @(negedge clk);
        end
        checks++;
        if (n_busy !== 3 || n_done !== 1 || done_at !== 3 || done_cnt !== 32'd3) begin
            errors++;
            $display("FAIL midrun_reset_rerun: busy=%0d pulses=%0d at=%0d cnt=%0d expected 3/1/3/3",
                     n_busy, n_done, done_at, done_cnt);
        end
    endtask

    task automatic test_phase();
        logic [5:0] ph_seq = '0;
        logic [5:0] en_seq = '0;
        logic [5:0] ph_exp;
        logic       hold_exp;
        logic       ph_done, ph_idle, busy_idle, busy_run, ph_restart;
`ifdef TICK_SCHEDULER_PHASE_EN
        ph_exp   = 6'b100110;
        hold_exp = 1'b1;
`else
        ph_exp   = 6'b000000;
        hold_exp = 1'b0;
`endif
        run_len = 32'd6; div_fast = 16'd2; div_med = 16'd3; div_slow = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ph_seq[i] = fast_ph;
            en_seq[i] = fast_en;
            @(negedge clk);
        end
        ph_done = fast_ph;
        start = 1'b1;
        @(negedge clk);
        ph_idle   = fast_ph;
        busy_idle = busy;
        @(negedge clk);
        start = 1'b0;
        busy_run   = busy;
        ph_restart = fast_ph;
        repeat (8) @(negedge clk);
        checks++;
        if (en_seq !== 6'b101010) begin errors++; $display("FAIL phase_en_seq: got %b expected 101010", en_seq); end
        checks++;
        if (ph_seq !== ph_exp) begin errors++; $display("FAIL phase_seq: got %b expected %b", ph_seq, ph_exp); end
        checks++;
        if (ph_done !== hold_exp || ph_idle !== hold_exp) begin
            errors++;
            $display("FAIL phase_hold: done=%b idle=%b expected %b", ph_done, ph_idle, hold_exp);
        end
        checks++;
        if (busy_idle !== 1'b0 || busy_run !== 1'b1) begin
            errors++;
            $display("FAIL earliest_restart: idle busy=%b run busy=%b expected 0/1", busy_idle, busy_run);
        end
        checks++;
        if (ph_restart !== 1'b0) begin errors++; $display("FAIL phase_clear_on_start: got %b expected 0", ph_restart); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bounded_run();
        test_free_run();
        test_start_stop_idle();
        test_start_during_run();
        test_reset_mid_run();
        test_phase();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
